// File: rtl/mul_sequencer.sv
// mul_sequencer -- unsigned 8x8 shift-add multiplier that borrows a shared ALU.
//
// A START in IDLE or FIN latches DATA1 (multiplicand) and DATA2 (multiplier).
// The block then spends eight RUN cycles owning the shared ALU. Each cycle the
// ALU adds the multiplicand (or 0) to the partial-product high byte, and the
// 16-bit {HI,LO} pair shifts right by one. A one-cycle FIN state then presents
// DONE with the registered product.
//
// Ports
//   CLK, RESET          clock; asynchronous active-high reset
//   START, DATA1, DATA2 multiply request and operands (sampled on accept)
//   ALU_RESULT          sum returned by the shared ALU
//   ALU_OWN             high while this block drives the ALU operand mux
//   ALU_SELECT          3'b001 (ADD) while owning the ALU, else 0
//   ALU_DATA1/2         ALU operands: partial-product high byte / gated MCAND
//   BUSY                CPU stall, high during RUN
//   DONE                one-cycle completion pulse
//   RESULT, RESULT_HI   product low / high byte, held until the next completion
//   ZERO                high when the registered 16-bit product is 0
module mul_sequencer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] DATA1,
    input  logic [7:0] DATA2,
    input  logic [7:0] ALU_RESULT,
    output logic       ALU_OWN,
    output logic [2:0] ALU_SELECT,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT,
    output logic [7:0] RESULT_HI,
    output logic       ZERO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [2:0] SEL_ADD  = 3'b001;
    localparam logic [2:0] SEL_NONE = 3'b000;

    state_t     state;
    logic [2:0] cnt;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] mcand;

    logic       carry;
    logic [7:0] hi_nxt;
    logic [7:0] lo_nxt;

    // The ALU only returns 8 bits. When an addend is applied, a wrapped sum
    // is detectable because it comes out smaller than the original HI.
    assign carry  = lo[0] & (ALU_RESULT < hi);
    assign hi_nxt = {carry, ALU_RESULT[7:1]};
    assign lo_nxt = {ALU_RESULT[0], lo[7:1]};

    // ALU operands are derived from registered state and the registered
    // ownership flag. They are therefore glitch-free for the whole RUN cycle.
    assign ALU_SELECT = ALU_OWN ? SEL_ADD : SEL_NONE;
    assign ALU_DATA1  = ALU_OWN ? hi : 8'd0;
    assign ALU_DATA2  = (ALU_OWN && lo[0]) ? mcand : 8'd0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            hi        <= 8'd0;
            lo        <= 8'd0;
            mcand     <= 8'd0;
            BUSY      <= 1'b0;
            ALU_OWN   <= 1'b0;
            DONE      <= 1'b0;
            RESULT    <= 8'd0;
            RESULT_HI <= 8'd0;
            ZERO      <= 1'b1;
        end else begin
            case (state)
                IDLE, FIN: begin
                    DONE <= 1'b0;
                    if (START) begin
                        state   <= RUN;
                        mcand   <= DATA1;
                        lo      <= DATA2;
                        hi      <= 8'd0;
                        cnt     <= 3'd0;
                        BUSY    <= 1'b1;
                        ALU_OWN <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // START is deliberately not looked at here.
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    // On the eighth iteration, CNT wraps from 7 back to 0.
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state     <= FIN;
                        BUSY      <= 1'b0;
                        ALU_OWN   <= 1'b0;
                        DONE      <= 1'b1;
                        RESULT    <= lo_nxt;
                        RESULT_HI <= hi_nxt;
                        ZERO      <= ({hi_nxt, lo_nxt} == 16'd0);
                    end
                end
                default: begin
                    state   <= IDLE;
                    BUSY    <= 1'b0;
                    ALU_OWN <= 1'b0;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer. The bench plays the shared ALU (an
// 8-bit adder). Expected values come from plain arithmetic: the product a*b,
// and, for the k-th iteration, the partial product of the low k multiplier
// bits shifted right by k.
module tb_mul_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [7:0] DATA1, DATA2, ALU_RESULT;
    logic       ALU_OWN;
    logic [2:0] ALU_SELECT;
    logic [7:0] ALU_DATA1, ALU_DATA2;
    logic       BUSY, DONE;
    logic [7:0] RESULT, RESULT_HI;
    logic       ZERO;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_lo, exp_hi;
    logic       exp_zero;

    mul_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START(START), .DATA1(DATA1), .DATA2(DATA2),
        .ALU_RESULT(ALU_RESULT), .ALU_OWN(ALU_OWN), .ALU_SELECT(ALU_SELECT),
        .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .BUSY(BUSY), .DONE(DONE),
        .RESULT(RESULT), .RESULT_HI(RESULT_HI), .ZERO(ZERO)
    );

    // Shared ALU: ADD when selected, otherwise 0.
    assign ALU_RESULT = (ALU_SELECT == 3'b001) ? 8'(ALU_DATA1 + ALU_DATA2) : 8'h00;

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_own"},  ALU_OWN, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_sel"},  ALU_SELECT, 0);
        chk({tag, "_d1"},   ALU_DATA1, 0);
        chk({tag, "_d2"},   ALU_DATA2, 0);
        chk({tag, "_res"},  RESULT, 0);
        chk({tag, "_reshi"}, RESULT_HI, 0);
        chk({tag, "_zero"}, ZERO, 1);
    endtask

    // Runs one multiply a*b and checks every RUN cycle plus the completion.
    // inject: in this RUN cycle, pulse START with 9*9 (0 = never).
    // pre:    START is already driven by the caller.
    // chain:  hold START high with na*nb during the FIN cycle.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input int inject,
                           input bit pre, input bit chain,
                           input logic [7:0] na, input logic [7:0] nb);
        int          k;
        int          j;
        logic [15:0] part;
        logic [15:0] prod;
        logic [7:0]  mask;
        if (!pre) begin
            @(negedge CLK);
            DATA1 = a; DATA2 = b; START = 1'b1;
        end
        @(negedge CLK);
        START = 1'b0;
        k = 1;
        while (DONE !== 1'b1 && k <= 20) begin
            j = k - 1;   // iterations already completed
            chk("busy", BUSY, 1);
            chk("own", ALU_OWN, 1);
            chk("sel", ALU_SELECT, 1);
            if (j < 8) begin
                mask = 8'((1 << j) - 1);
                part = (16'(a) * 16'(b & mask)) >> j;
                chk("alu_d1", ALU_DATA1, part[7:0]);
                chk("alu_d2", ALU_DATA2, b[j] ? a : 8'd0);
            end
            chk("hold_res", RESULT, exp_lo);
            chk("hold_reshi", RESULT_HI, exp_hi);
            chk("hold_zero", ZERO, exp_zero);
            if (k == inject) begin
                START = 1'b1; DATA1 = 8'd9; DATA2 = 8'd9;
            end else if (k == inject + 1) begin
                START = 1'b0;
            end
            @(negedge CLK);
            k++;
        end
        prod     = 16'(a) * 16'(b);
        exp_lo   = prod[7:0];
        exp_hi   = prod[15:8];
        exp_zero = (prod == 16'd0);
        chk("latency", k, 9);
        chk("done", DONE, 1);
        chk("busy_fin", BUSY, 0);
        chk("own_fin", ALU_OWN, 0);
        chk("sel_fin", ALU_SELECT, 0);
        chk("result", RESULT, exp_lo);
        chk("result_hi", RESULT_HI, exp_hi);
        chk("zero", ZERO, exp_zero);
        if (chain) begin
            START = 1'b1; DATA1 = na; DATA2 = nb;
        end else begin
            @(negedge CLK);
            chk("done_pulse", DONE, 0);
            chk("idle_busy", BUSY, 0);
            chk("idle_res", RESULT, exp_lo);
            chk("idle_reshi", RESULT_HI, exp_hi);
        end
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; DATA1 = 8'd0; DATA2 = 8'd0;
        exp_lo = 8'd0; exp_hi = 8'd0; exp_zero = 1'b1;
        repeat (2) @(negedge CLK);
        chk_reset_outputs("rst");
        RESET = 1'b0;

        run_mul(8'd13,  8'd11,  0, 1'b0, 1'b0, 8'd0, 8'd0);
        run_mul(8'd255, 8'd255, 0, 1'b0, 1'b0, 8'd0, 8'd0);
        run_mul(8'd0,   8'd200, 0, 1'b0, 1'b0, 8'd0, 8'd0);
        run_mul(8'd6,   8'd7,   3, 1'b0, 1'b0, 8'd0, 8'd0);

        // Back-to-back accept from FIN.
        run_mul(8'd17, 8'd5,   0, 1'b0, 1'b1, 8'd2, 8'd128);
        run_mul(8'd2,  8'd128, 0, 1'b1, 1'b0, 8'd0, 8'd0);

        // Reset in the middle of a run, at CNT=4.
        @(negedge CLK);
        DATA1 = 8'd200; DATA2 = 8'd150; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        chk("pre_rst_busy", BUSY, 1);
        #2 RESET = 1'b1;
        #1 chk_reset_outputs("async_rst");
        exp_lo = 8'd0; exp_hi = 8'd0; exp_zero = 1'b1;
        START = 1'b1; DATA1 = 8'd9; DATA2 = 8'd9;
        @(negedge CLK);
        chk("rst_start_ignored", BUSY, 0);
        chk("rst_no_done", DONE, 0);
        RESET = 1'b0; DATA1 = 8'd3; DATA2 = 8'd5; START = 1'b1;
        run_mul(8'd3, 8'd5, 0, 1'b1, 1'b0, 8'd0, 8'd0);

        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            int         inj;
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            inj = $urandom_range(0, 6);
            run_mul(ra, rb, inj, 1'b0, 1'b0, 8'd0, 8'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
